// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and constants for the load/store unit
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WRITE  = 2'd2,
    S_DONE   = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Smallest address width that still has the two byte-lane bits plus a word index.
  localparam int LSU_MIN_ADDR_W = 3;

  // True for the five RV32I load/store funct3 encodings this unit accepts.
  function automatic logic f3_is_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte/half lane extraction and store merge (combinational)
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [15:0] i_sdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_extract,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_signed;

  assign w_byte   = i_word[8*i_addr_lo +: 8];
  assign w_half   = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
  assign w_signed = ~i_funct3[2];

  // Extract the addressed lane and sign- or zero-extend it to a full word.
  always_comb begin
    o_extract = i_word;
    case (i_funct3[1:0])
      2'b00:   o_extract = {{24{w_signed & w_byte[7]}}, w_byte};
      2'b01:   o_extract = {{16{w_signed & w_half[15]}}, w_half};
      default: o_extract = i_word;
    endcase
  end

  // Replace only the addressed lane of the read word with the store data.
  always_comb begin
    o_merged = i_word;
    case (i_funct3[1:0])
      2'b00: o_merged[8*i_addr_lo +: 8] = i_sdata[7:0];
      2'b01: begin
        if (i_addr_lo[1]) o_merged[31:16] = i_sdata;
        else              o_merged[15:0]  = i_sdata;
      end
      default: o_merged = i_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store FSM with read-modify-write sub-word stores; LSU_MISALIGN_TRAP_EN traps misaligned accesses
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [2:0]        i_funct3,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [31:0]       i_storeData,
  output logic              o_busy,
  output logic              o_done,
  output logic [31:0]       o_loadData,
  output logic              o_error,
  output logic [ADDR_W-1:0] o_memAddress,
  output logic              o_memWriteEnable,
  output logic [31:0]       o_memWriteData,
  input  logic [31:0]       i_memReadData
);

  if (ADDR_W < LSU_MIN_ADDR_W) begin : g_addr_w_check
    $error("load_store_unit: ADDR_W too small");
  end

  lsu_state_t        r_state, w_next;
  logic              r_we;
  logic [2:0]        r_funct3;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_sdata;
  logic [31:0]       r_merged;
  logic [31:0]       r_load_data;
  logic              r_error;

  logic              w_misalign;
  logic              w_req_err;
  logic [ADDR_W-1:0] w_eff_addr;
  logic [31:0]       w_extract;
  logic [31:0]       w_merge;
  logic              w_we;
  logic              w_is_word;

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = ((i_funct3[1:0] == 2'b01) && i_address[0]) ||
                      ((i_funct3[1:0] == 2'b10) && (i_address[1:0] != 2'b00));
  assign w_eff_addr = i_address;
`else
  assign w_misalign = 1'b0;
  // Misaligned halfword/word addresses are rounded down to their natural boundary.
  always_comb begin
    w_eff_addr = i_address;
    if (i_funct3[1:0] == 2'b01)      w_eff_addr[0]   = 1'b0;
    else if (i_funct3[1:0] == 2'b10) w_eff_addr[1:0] = 2'b00;
  end
`endif

  assign w_req_err = ~f3_is_legal(i_funct3) | w_misalign;
  assign w_is_word = (r_funct3[1:0] == 2'b10);

  lsu_lane_align u_lane_align (
    .i_word    (i_memReadData),
    .i_sdata   (r_sdata[15:0]),
    .i_addr_lo (r_addr[1:0]),
    .i_funct3  (r_funct3),
    .o_extract (w_extract),
    .o_merged  (w_merge)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state: errors skip the memory, sub-word stores take the extra WRITE cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_req) w_next = w_req_err ? S_DONE : S_ACCESS;
      S_ACCESS: w_next = (r_we && !w_is_word) ? S_WRITE : S_DONE;
      S_WRITE:  w_next = S_DONE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Request capture, load result and merged word registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_we        <= 1'b0;
      r_funct3    <= 3'b000;
      r_addr      <= '0;
      r_sdata     <= 32'd0;
      r_merged    <= 32'd0;
      r_load_data <= 32'd0;
      r_error     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req) begin
            r_we     <= i_we;
            r_funct3 <= i_funct3;
            r_addr   <= w_eff_addr;
            r_sdata  <= i_storeData;
            r_error  <= w_req_err;
          end
        end
        S_ACCESS: begin
          if (!r_we) r_load_data <= w_extract;
          else       r_merged    <= w_merge;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; the write strobe is masked by reset so a WRITE in flight is dropped.
  always_comb begin
    w_we           = 1'b0;
    o_memWriteData = 32'd0;
    case (r_state)
      S_ACCESS: begin
        if (r_we && w_is_word) begin
          w_we           = 1'b1;
          o_memWriteData = r_sdata;
        end
      end
      S_WRITE: begin
        w_we           = 1'b1;
        o_memWriteData = r_merged;
      end
      default: ;
    endcase
  end

  assign o_busy           = (r_state != S_IDLE);
  assign o_done           = (r_state == S_DONE);
  assign o_error          = (r_state == S_DONE) & r_error;
  assign o_loadData       = r_load_data;
  assign o_memAddress     = {r_addr[ADDR_W-1:2], 2'b00};
  assign o_memWriteEnable = w_we & ~i_rst;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator-side memory access controller for the RISC-V data path. It sits between the core's execute stage and the word-wide data memory. It turns RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses. The memory has no byte enables, so sub-word stores are done as an internal read-modify-write sequence.

## Interface
Parameters:
- ADDR_W, 32, address width of core and memory ports.

Ports (clock and reset first):
- i_clk  input  1  system clock; single clock domain.
- i_rst  input  1  reset, synchronous, active-high.
- i_req  input  1  core request; sampled only in IDLE.
- i_we  input  1  1 = store, 0 = load.
- i_funct3  input  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- i_address  input  ADDR_W  byte address.
- i_storeData  input  32  store data; low byte/half used for SB/SH.
- o_busy  output  1  high in every state except IDLE.
- o_done  output  1  one-cycle completion pulse.
- o_loadData  output  32  extended load result; valid while o_done=1, held until next done.
- o_error  output  1  valid with o_done; illegal funct3 or misaligned access.
- o_memAddress  output  ADDR_W  word-aligned address to memory; bits [1:0] always 0.
- o_memWriteEnable  output  1  memory write strobe.
- o_memWriteData  output  32  full word to memory.
- i_memReadData  input  32  combinational read data for o_memAddress.

## Operation
- State machine states: IDLE, ACCESS, WRITE, DONE.
- IDLE:
  - With i_req=1, register i_we, i_funct3, i_address and i_storeData.
  - If the request is illegal or misaligned, go to DONE with error set.
  - Otherwise go to ACCESS.
- ACCESS:
  - Drive o_memAddress = {addr[ADDR_W-1:2], 2'b00}.
  - Load: capture the lane-extracted word; go to DONE.
  - SW: assert o_memWriteEnable with o_memWriteData = storeData; go to DONE.
  - SB/SH: capture i_memReadData and merge the store lane into it; go to WRITE.
- WRITE: drive o_memWriteEnable=1 and the merged word at the same address; go to DONE.
- DONE: o_done=1; go to IDLE.
- Lane extract:
  - Byte selected by addr[1:0]; half selected by addr[1].
  - B/H sign-extend; BU/HU zero-extend.
- Merge: only the addressed byte/half is replaced; other bytes keep their read value.
- Illegal funct3 (011, 110, 111):
  - o_error=1, no memory access, o_loadData unchanged.
  - Independent of configuration.
- Requests while o_busy=1 are ignored; the core must hold i_req until o_done.

## Timing
- Reset values:
  - State IDLE; o_busy, o_done, o_error and o_memWriteEnable are 0.
  - o_loadData, o_memAddress and o_memWriteData are 0.
- Request accepted at the edge ending cycle N.
- Load: ACCESS in cycle N+1; o_done in N+2.
- SW: write strobe in N+1; o_done in N+2.
- SB/SH: read in N+1, write strobe in N+2; o_done in N+3.
- Error: o_done/o_error in N+1; no write strobe.
- o_memWriteEnable is high for exactly one cycle per store.
- Back-to-back: the next request can be accepted in the cycle after DONE, which is IDLE.
- Reset mid-operation (any state): the next edge returns to IDLE with all strobes low. An in-flight WRITE is suppressed if reset is sampled at the same edge.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0, completes with o_error=1 and no memory access.
- Undefined:
  - The address is force-aligned: the low bit is cleared for halfword, the low two bits for word.
  - The access proceeds normally; o_error is asserted only for illegal funct3.

## Structure
- Package lsu_pkg holds:
  - The state enum type.
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - A width-check constant for ADDR_W.
- Sub-module lsu_lane_align, combinational, holds both paths:
  - Extract: word, addr[1:0], funct3 → extended data.
  - Merge: word, store data, addr[1:0], funct3 → merged word.
- The top level holds the FSM and registers only.

## Test plan
- Memory[0x10]=0x8899AABB; LB 0x11 → o_loadData=0xFFFFFFAA at N+2; LBU 0x11 → 0x000000AA.
- LH 0x12 → 0xFFFF8899; LHU 0x12 → 0x00008899; no write strobe on any load.
- SH 0x12 data 0x00001234 → read at N+1, one write of 0x1234AABB to address 0x10 at N+2, o_done at N+3.
- SW 0x20 data 0xDEADBEEF → single write strobe at N+1, o_done at N+2; readback LW 0x20 = 0xDEADBEEF.
- LW 0x13:
  - With the macro: o_error=1 at N+1, no access.
  - Without it: reads word 0x10, o_error=0.
  - funct3=011 → o_error=1 in both builds.
- Assert i_rst during WRITE of an SB → no write strobe, memory unchanged, state IDLE, all outputs at reset values next cycle.
